// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, level start / finish handshake.
module seq_divider #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  input  logic           start,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           finish,
  output logic           busy,
  output logic           div_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  sq_q, sq_d;
  logic [N-1:0]  dv_q, dv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          err_q, err_d;

  logic [N:0]    trial;
  logic          fits;
  logic [N:0]    r_step;
  logic [N:0]    sq_shift;
  logic [N-1:0]  sq_step;
  logic          ovf;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {r_q[N-1:0], sq_q[N-1]};
    fits     = (trial >= {1'b0, dv_q});
    r_step   = fits ? (trial - {1'b0, dv_q}) : trial;
    sq_shift = {sq_q, fits};
    sq_step  = sq_shift[N-1:0];
    ovf      = (dividend[2*N-1:N] >= divisor);
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    sq_d    = sq_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ovf) begin
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            r_d     = {1'b0, dividend[2*N-1:N]};
            sq_d    = dividend[N-1:0];
            dv_d    = divisor;
            cnt_d   = CNT_INIT;
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_d   = r_step;
        sq_d  = sq_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          quot_d  = sq_step;
          rem_d   = r_step[N-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      sq_q    <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      sq_q    <= sq_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    busy      = (state_q == S_RUN);
    finish    = (state_q == S_DONE);
    quotient  = quot_q;
    remainder = rem_q;
    div_err   = err_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus
// random operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int N = 5;
  localparam int QMAX = (1 << N) - 1;

  logic           clk;
  logic           reset;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           start;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           finish;
  logic           busy;
  logic           div_err;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .finish    (finish),
    .busy      (busy),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; error when divisor is zero
  // or the true quotient does not fit in N bits.
  task automatic model(input int dvd, input int dvs,
                       output int q, output int r, output int e);
    if (dvs == 0 || (dvd / dvs) > QMAX) begin
      q = QMAX; r = 0; e = 1;
    end else begin
      q = dvd / dvs; r = dvd % dvs; e = 0;
    end
  endtask

  // Launch one operation from IDLE, optionally scramble inputs during RUN,
  // optionally hold start after finish, then release start.
  task automatic do_op(input string tag, input int dvd, input int dvs,
                       input bit scramble, input int hold);
    int edges, busy_cnt, both, q, r, e, stay;
    model(dvd, dvs, q, r, e);
    @(negedge clk);
    dividend = (2*N)'(dvd);
    divisor  = N'(dvs);
    start    = 1'b1;
    edges    = 0;
    busy_cnt = 0;
    both     = 0;
    while (!finish && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && finish) both++;
      if (scramble && busy) begin
        dividend = (2*N)'($urandom);
        divisor  = N'($urandom);
      end
    end
    chk({tag, "_latency"}, edges, e ? 1 : N + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, e ? 0 : N);
    chk({tag, "_busy_and_finish"}, both, 0);
    chk({tag, "_quotient"}, int'(quotient), q);
    chk({tag, "_remainder"}, int'(remainder), r);
    chk({tag, "_div_err"}, int'(div_err), e);
    if (hold > 0) begin
      stay = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (finish && !busy && quotient == N'(q)) stay++;
      end
      chk({tag, "_hold_finish"}, stay, hold);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_finish_drop"}, int'(finish), 0);
    chk({tag, "_result_held"}, int'(quotient), q);
  endtask

  initial begin
    int dvs, dvd, edges;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_div_err", int'(div_err), 0);
    reset = 1'b0;
    @(negedge clk);

    do_op("d780_30", 780, 30, 1'b0, 0);
    do_op("d169_13", 169, 13, 1'b0, 0);
    do_op("d100_7", 100, 7, 1'b0, 0);
    do_op("d991_31", 991, 31, 1'b0, 0);
    do_op("d1000_31", 1000, 31, 1'b0, 0);
    do_op("d500_0", 500, 0, 1'b0, 0);
    do_op("d0_0", 0, 0, 1'b0, 0);
    do_op("d0_1", 0, 1, 1'b0, 0);
    do_op("d1023_1", 1023, 1, 1'b0, 0);
    do_op("d780_30_hold", 780, 30, 1'b0, 20);
    do_op("d100_7_scr", 100, 7, 1'b1, 0);

    // Reset sampled at the third RUN edge, start kept high throughout.
    @(negedge clk);
    dividend = 10'd780;
    divisor  = 5'd30;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_finish", int'(finish), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_div_err", int'(div_err), 0);
    reset = 1'b0;
    edges = 0;
    while (!finish && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("relaunch_latency", edges, N + 1);
    chk("relaunch_quotient", int'(quotient), 26);
    chk("relaunch_remainder", int'(remainder), 0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("relaunch_finish_drop", int'(finish), 0);

    for (int k = 0; k < 40; k++) begin
      dvs = int'($urandom_range(0, QMAX));
      if (k % 2 == 0 && dvs > 0)
        dvd = int'($urandom_range(0, dvs * (QMAX + 1) - 1));
      else
        dvd = int'($urandom_range(0, (1 << (2 * N)) - 1));
      do_op($sformatf("rnd%0d", k), dvd, dvs, k % 3 == 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
